// File: rtl/pipeline_pkg.sv
// Shared encodings for the execute stage: ALU ops, forward selects, branch conditions.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RD      = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUM    = 2'b10,
    FWD_RD_ALT  = 2'b11
  } fwd_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Combinational ALU for the execute stage; shifts use the low 5 bits of src_b.
module alu
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [2:0]            alu_control,
  output logic [DATA_WIDTH-1:0] alu_result
);

  logic [4:0] shamt;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_control))
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_result = src_a << shamt;
      ALU_SRL: alu_result = src_a >> shamt;
      default: alu_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_mem_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              EN,
  input  logic                              CLR,
  input  logic                              RegWriteE,
  input  logic                              MemWriteE,
  input  logic                              JumpE,
  input  logic                              BranchE,
  input  logic                              ALUsrcE,
  input  logic                              JalrE,
  input  logic [1:0]                        ResultSrcE,
  input  logic [2:0]                        ALUControlE,
  input  logic [2:0]                        Funct3E,
  input  logic [DATA_WIDTH-1:0]             RD1E,
  input  logic [DATA_WIDTH-1:0]             RD2E,
  input  logic [DATA_WIDTH-1:0]             PCE,
  input  logic [DATA_WIDTH-1:0]             ImmExtE,
  input  logic [DATA_WIDTH-1:0]             PCPlus4E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
  input  logic [1:0]                        ForwardAE,
  input  logic [1:0]                        ForwardBE,
  input  logic [DATA_WIDTH-1:0]             ResultW,
  output logic                              PCSrcE,
  output logic [DATA_WIDTH-1:0]             PCTargetE,
  output logic                              RegWriteM,
  output logic                              MemWriteM,
  output logic [1:0]                        ResultSrcM,
  output logic [DATA_WIDTH-1:0]             ALUResultM,
  output logic [DATA_WIDTH-1:0]             WriteDataM,
  output logic [DATA_WIDTH-1:0]             PCPlus4M,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] RdM
);

  logic [DATA_WIDTH-1:0] src_a_e;
  logic [DATA_WIDTH-1:0] write_data_e;
  logic [DATA_WIDTH-1:0] src_b_e;
  logic [DATA_WIDTH-1:0] alu_result_e;
  logic [DATA_WIDTH-1:0] jalr_sum;
  logic                  branch_cond;

  always_comb begin
    src_a_e = RD1E;
    case (fwd_sel_e'(ForwardAE))
      FWD_RESULTW: src_a_e = ResultW;
      FWD_ALUM:    src_a_e = ALUResultM;
      default:     src_a_e = RD1E;
    endcase
  end

  always_comb begin
    write_data_e = RD2E;
    case (fwd_sel_e'(ForwardBE))
      FWD_RESULTW: write_data_e = ResultW;
      FWD_ALUM:    write_data_e = ALUResultM;
      default:     write_data_e = RD2E;
    endcase
  end

  assign src_b_e = ALUsrcE ? ImmExtE : write_data_e;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .src_a       (src_a_e),
    .src_b       (src_b_e),
    .alu_control (ALUControlE),
    .alu_result  (alu_result_e)
  );

  // Branches compare the forwarded register operands, never the immediate.
  always_comb begin
    branch_cond = 1'b0;
    case (Funct3E)
      F3_BEQ:  branch_cond = (src_a_e == write_data_e);
      F3_BNE:  branch_cond = (src_a_e != write_data_e);
      F3_BLT:  branch_cond = ($signed(src_a_e) <  $signed(write_data_e));
      F3_BGE:  branch_cond = ($signed(src_a_e) >= $signed(write_data_e));
      F3_BLTU: branch_cond = (src_a_e <  write_data_e);
      F3_BGEU: branch_cond = (src_a_e >= write_data_e);
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & branch_cond);
  assign jalr_sum  = src_a_e + ImmExtE;
  assign PCTargetE = JalrE ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : (PCE + ImmExtE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (CLR) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (EN) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result_e;
      WriteDataM <= write_data_e;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

endmodule
